// File: rtl/niosv_soc_gpo_pulse.sv
// -----------------------------------------------------------------------------
// niosv_soc_gpo_pulse
//
// Avalon-MM general purpose output block. It holds a DATA register that drives
// the output pins. It can also fire a timed pulse that XORs a mask onto the
// pins for a programmable number of clock cycles.
//
// Optional feature macro: NIOSV_SOC_GPO_PULSE_IRQ_EN
//   defined   : IRQ_MASK register (addr 4, bit0) and a registered level irq
//               that follows done & IRQ_MASK[0].
//   undefined : irq is tied low, addr 4 reads 0 and writes to it are ignored.
//
// Register map (word addresses):
//   0 DATA      rw  output data, WIDTH bits
//   1 PULSE     wo  a nonzero mask starts a pulse while idle
//   2 PULSE_LEN rw  pulse length in cycles, 16 bits (0 behaves as 1)
//   3 STATUS    rw1c  bit0 busy, bit1 done (sticky), bit2 overrun (sticky)
//   4 IRQ_MASK  rw  bit0 enables irq on done
//   5 OUTSET    wo  ORs writedata into DATA
//   6 OUTCLR    wo  clears the DATA bits that are set in writedata
//   7 reserved      reads 0
//
// Ports:
//   clk        : clock, all logic on the rising edge
//   reset_n    : asynchronous active-low reset
//   address    : slave word address
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data, bits above WIDTH are ignored for DATA/PULSE
//   readdata   : registered read data, one cycle latency, zero-extended
//   out_port   : registered output pins
//   irq        : level interrupt signalling pulse completion
// -----------------------------------------------------------------------------
module niosv_soc_gpo_pulse #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_mask;
    logic [15:0]      r_cnt;
    logic [15:0]      r_len;
    logic             r_done;
    logic             r_overrun;
    logic [WIDTH-1:0] r_out_port;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_data_next;
    logic             w_pulse_wr;
    logic             w_start;
    logic             w_end;
    logic             w_active_next;
    logic [WIDTH-1:0] w_mask_next;
    logic             w_done_clr;
    logic             w_overrun_clr;
    logic             w_overrun_set;
    logic [31:0]      w_data_ext;
    logic [31:0]      w_rd_next;
    logic             w_irq_mask;
    logic             w_unused;

    // Parts of writedata are used only by some registers; reduce the bus so every bit is referenced.
    assign w_unused = ^writedata;

    // Write decode, next DATA value and pulse start/end conditions.
    always_comb begin
        w_wr          = chipselect & ~write_n;
        w_wdata       = writedata[WIDTH-1:0];
        w_data_next   = r_data;
        if (w_wr) begin
            case (address)
                3'd0:    w_data_next = w_wdata;
                3'd5:    w_data_next = r_data | w_wdata;
                3'd6:    w_data_next = r_data & ~w_wdata;
                default: w_data_next = r_data;
            endcase
        end else begin
            w_data_next = r_data;
        end
        w_pulse_wr    = w_wr && (address == 3'd1);
        w_start       = w_pulse_wr && (r_state == ST_IDLE) && (w_wdata != '0);
        w_overrun_set = w_pulse_wr && (r_state == ST_ACTIVE);
        w_end         = (r_state == ST_ACTIVE) && (r_cnt == 16'd1);
        w_active_next = w_start || ((r_state == ST_ACTIVE) && !w_end);
        if (w_start) begin
            w_mask_next = w_wdata;
        end else if (w_end) begin
            w_mask_next = '0;
        end else begin
            w_mask_next = r_mask;
        end
        w_done_clr    = w_wr && (address == 3'd3) && writedata[1];
        w_overrun_clr = w_wr && (address == 3'd3) && writedata[2];
    end

    // Read data mux; DATA is zero-extended through a 32-bit intermediate so WIDTH=32 also works.
    always_comb begin
        w_data_ext              = 32'd0;
        w_data_ext[WIDTH-1:0]   = r_data;
        case (address)
            3'd0:    w_rd_next = w_data_ext;
            3'd2:    w_rd_next = {16'd0, r_len};
            3'd3:    w_rd_next = {29'd0, r_overrun, r_done, (r_state == ST_ACTIVE)};
            3'd4:    w_rd_next = {31'd0, w_irq_mask};
            default: w_rd_next = 32'd0;
        endcase
    end

    // Pulse FSM with DATA, mask, counter, sticky flags and the output pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_data     <= RESET_VALUE[WIDTH-1:0];
            r_mask     <= '0;
            r_cnt      <= 16'd0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
            r_out_port <= RESET_VALUE[WIDTH-1:0];
        end else begin
            r_data <= w_data_next;
            r_mask <= w_mask_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_ACTIVE;
                        // A programmed length of 0 still produces a single-cycle pulse.
                        r_cnt   <= (r_len == 16'd0) ? 16'd1 : r_len;
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= r_cnt;
                    end
                end
                ST_ACTIVE: begin
                    if (w_end) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_state <= ST_ACTIVE;
                        r_cnt   <= r_cnt - 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 16'd0;
                end
            endcase
            // A set in the same cycle as its clear wins.
            if (w_end) begin
                r_done <= 1'b1;
            end else if (w_done_clr) begin
                r_done <= 1'b0;
            end else begin
                r_done <= r_done;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (w_overrun_clr) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
            // The pins are built from next-state values so a write shows up right after its edge.
            r_out_port <= w_data_next ^ (w_active_next ? w_mask_next : '0);
        end
    end

    // PULSE_LEN register and registered read data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len      <= 16'd0;
            r_readdata <= 32'd0;
        end else begin
            if (w_wr && (address == 3'd2)) begin
                r_len <= writedata[15:0];
            end else begin
                r_len <= r_len;
            end
            r_readdata <= w_rd_next;
        end
    end

`ifdef NIOSV_SOC_GPO_PULSE_IRQ_EN
    logic r_irq_mask;
    logic r_irq;

    // IRQ_MASK register and the registered interrupt level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && (address == 3'd4)) begin
                r_irq_mask <= writedata[0];
            end else begin
                r_irq_mask <= r_irq_mask;
            end
            r_irq <= r_done & r_irq_mask;
        end
    end

    assign w_irq_mask = r_irq_mask;
    assign irq        = r_irq;
`else
    assign w_irq_mask = 1'b0;
    assign irq        = 1'b0;
`endif

    assign readdata = r_readdata;
    assign out_port = r_out_port;

endmodule

// File: tb/tb_niosv_soc_gpo_pulse.sv
// -----------------------------------------------------------------------------
// Self-checking bench for niosv_soc_gpo_pulse (WIDTH=8, RESET_VALUE=0).
// A vector table covers register access and DATA updates. Hand-written
// sequences cover pulse timing, overrun, interrupt and reset abort.
// -----------------------------------------------------------------------------
module tb_niosv_soc_gpo_pulse;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    int errors;
    int checks;

    niosv_soc_gpo_pulse #(
        .WIDTH      (8),
        .RESET_VALUE(32'd0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, clock edge, sample 1 ns later.
    task automatic cyc(input logic [2:0] a, input logic wr, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = ~wr;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;

        // addr, wr, wdata, expected out_port after edge, expected readdata after edge
        vecs[0]  = '{3'd0, 1'b1, 32'h0000_00A5, 8'hA5, 32'h0};
        vecs[1]  = '{3'd0, 1'b0, 32'h0,         8'hA5, 32'h0000_00A5};
        vecs[2]  = '{3'd5, 1'b1, 32'h0000_000F, 8'hAF, 32'h0};
        vecs[3]  = '{3'd6, 1'b1, 32'h0000_0081, 8'h2E, 32'h0};
        vecs[4]  = '{3'd0, 1'b0, 32'h0,         8'h2E, 32'h0000_002E};
        vecs[5]  = '{3'd2, 1'b1, 32'h0001_2345, 8'h2E, 32'h0};
        vecs[6]  = '{3'd2, 1'b0, 32'h0,         8'h2E, 32'h0000_2345};
        vecs[7]  = '{3'd7, 1'b0, 32'h0,         8'h2E, 32'h0};
        vecs[8]  = '{3'd0, 1'b1, 32'hFFFF_FF00, 8'h00, 32'h0000_002E};
        vecs[9]  = '{3'd0, 1'b0, 32'h0,         8'h00, 32'h0};
        vecs[10] = '{3'd1, 1'b1, 32'h0000_0100, 8'h00, 32'h0};
        vecs[11] = '{3'd3, 1'b0, 32'h0,         8'h00, 32'h0};

        // Reset state
        #12;
        check("reset out_port", {24'd0, out_port}, 32'h0);
        check("reset readdata", readdata, 32'h0);
        check("reset irq", {31'd0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].addr, vecs[i].wr, vecs[i].wdata);
            check($sformatf("vec%0d out_port", i), {24'd0, out_port}, {24'd0, vecs[i].exp_out});
            check($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
        end

        // 5-cycle pulse with mask 0x81
        cyc(3'd2, 1'b1, 32'd5);
        cyc(3'd1, 1'b1, 32'h81);
        check("len5 pulse c0", {24'd0, out_port}, 32'h81);
        for (int i = 1; i < 5; i++) begin
            cyc(3'd3, 1'b0, 32'd0);
            check($sformatf("len5 pulse c%0d", i), {24'd0, out_port}, 32'h81);
        end
        cyc(3'd3, 1'b0, 32'd0);
        check("len5 pulse end", {24'd0, out_port}, 32'h00);
        cyc(3'd3, 1'b0, 32'd0);
        check("len5 status", readdata, 32'h2);
        cyc(3'd3, 1'b1, 32'h2);
        cyc(3'd3, 1'b0, 32'd0);
        check("done cleared", readdata, 32'h0);

        // PULSE_LEN=0 behaves as a single-cycle pulse
        cyc(3'd2, 1'b1, 32'd0);
        cyc(3'd1, 1'b1, 32'h01);
        check("len0 pulse on", {24'd0, out_port}, 32'h01);
        cyc(3'd3, 1'b0, 32'd0);
        check("len0 pulse off", {24'd0, out_port}, 32'h00);
        check("len0 busy read", readdata, 32'h1);
        cyc(3'd3, 1'b0, 32'd0);
        check("len0 done", readdata, 32'h2);
        cyc(3'd3, 1'b1, 32'h2);

        // Overrun: second PULSE write during an active pulse is ignored
        cyc(3'd2, 1'b1, 32'd10);
        cyc(3'd1, 1'b1, 32'h01);
        cyc(3'd3, 1'b0, 32'd0);
        cyc(3'd3, 1'b0, 32'd0);
        cyc(3'd1, 1'b1, 32'h02);
        check("ovr out after 2nd", {24'd0, out_port}, 32'h01);
        cyc(3'd3, 1'b0, 32'd0);
        check("ovr status busy", readdata, 32'h5);
        for (int i = 5; i < 10; i++) begin
            cyc(3'd3, 1'b0, 32'd0);
            check($sformatf("ovr pulse c%0d", i), {24'd0, out_port}, 32'h01);
        end
        cyc(3'd3, 1'b0, 32'd0);
        check("ovr pulse end", {24'd0, out_port}, 32'h00);
        cyc(3'd3, 1'b0, 32'd0);
        check("ovr status after", readdata, 32'h6);
        cyc(3'd3, 1'b1, 32'h6);
        cyc(3'd3, 1'b0, 32'd0);
        check("ovr flags cleared", readdata, 32'h0);

        // Interrupt and clear/set collision
        cyc(3'd4, 1'b1, 32'h1);
        cyc(3'd4, 1'b0, 32'd0);
`ifdef NIOSV_SOC_GPO_PULSE_IRQ_EN
        check("irq mask read", readdata, 32'h1);
`else
        check("irq mask read", readdata, 32'h0);
`endif
        cyc(3'd2, 1'b1, 32'd2);
        cyc(3'd1, 1'b1, 32'h01);
        cyc(3'd3, 1'b0, 32'd0);
        cyc(3'd3, 1'b0, 32'd0);
        check("irq before done seen", {31'd0, irq}, 32'h0);
        cyc(3'd3, 1'b0, 32'd0);
`ifdef NIOSV_SOC_GPO_PULSE_IRQ_EN
        check("irq after done", {31'd0, irq}, 32'h1);
`else
        check("irq after done", {31'd0, irq}, 32'h0);
`endif
        cyc(3'd3, 1'b1, 32'h2);
        cyc(3'd3, 1'b0, 32'd0);
        check("irq after clear", {31'd0, irq}, 32'h0);
        cyc(3'd1, 1'b1, 32'h01);
        cyc(3'd3, 1'b0, 32'd0);
        cyc(3'd3, 1'b1, 32'h2);
        cyc(3'd3, 1'b0, 32'd0);
        check("set wins over clear", readdata, 32'h2);
        cyc(3'd3, 1'b1, 32'h2);
        cyc(3'd4, 1'b1, 32'h0);

        // Reset in the middle of a long pulse
        cyc(3'd0, 1'b1, 32'h3C);
        cyc(3'd2, 1'b1, 32'd100);
        cyc(3'd1, 1'b1, 32'h01);
        check("long pulse on", {24'd0, out_port}, 32'h3D);
        for (int i = 1; i < 20; i++) begin
            cyc(3'd3, 1'b0, 32'd0);
        end
        check("long pulse mid", {24'd0, out_port}, 32'h3D);
        reset_n = 1'b0;
        #1;
        check("reset abort out_port", {24'd0, out_port}, 32'h0);
        check("reset abort readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(3'd3, 1'b0, 32'd0);
        check("status after reset", readdata, 32'h0);
        cyc(3'd2, 1'b0, 32'd0);
        check("len after reset", readdata, 32'h0);
        for (int i = 0; i < 110; i++) begin
            cyc(3'd3, 1'b0, 32'd0);
        end
        check("no done after abort", readdata, 32'h0);
        check("out idle after abort", {24'd0, out_port}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/niosv_soc_gpo_pulse.md
NIOSV_SOC_GPO_PULSE -- requirements
Module: niosv_soc_gpo_pulse

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning output port width (1..32).
REQ-002 SHALL have parameter RESET_VALUE, default 0, meaning DATA/out_port value after reset.
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port address  input  3  Avalon-MM slave word address.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port write_n  input  1  active-low write strobe, valid with chipselect.
REQ-008 SHALL have port writedata  input  32  write data; bits above WIDTH ignored.
REQ-009 SHALL have port readdata  output  32  registered read data, zero-extended.
REQ-010 SHALL have port out_port  output  WIDTH  registered output pins.
REQ-011 SHALL have port irq  output  1  level interrupt, pulse-done.

Function
REQ-012 SHALL decode a write as chipselect & ~write_n; register map: 0 DATA rw, 1 PULSE wo, 2 PULSE_LEN rw (16 bits), 3 STATUS, 4 IRQ_MASK rw (bit0), 5 OUTSET wo, 6 OUTCLR wo, 7 reserved (reads 0).
REQ-013 SHALL drive readdata one cycle after address is presented (read latency 1), updating every cycle independent of chipselect; write-only addresses read 0.
REQ-014 SHALL update DATA: addr0 write loads writedata[WIDTH-1:0]; addr5 write ORs it in; addr6 write clears bits set in writedata; effect visible on out_port the next cycle.
REQ-015 SHALL implement FSM states IDLE and ACTIVE; reset state IDLE.
REQ-016 SHALL, in IDLE on addr1 write with nonzero writedata[WIDTH-1:0], latch pulse mask, load counter with PULSE_LEN (0 treated as 1), enter ACTIVE next cycle.
REQ-017 SHALL ignore addr1 write with zero mask (no state change, no flags).
REQ-018 SHALL drive out_port = DATA ^ mask while ACTIVE, DATA otherwise; pulse width on out_port exactly max(PULSE_LEN,1) cycles.
REQ-019 SHALL decrement counter each ACTIVE cycle; at counter==1 return to IDLE, clear mask, set STATUS.done.
REQ-020 SHALL, on addr1 write while ACTIVE, leave pulse unaffected and set sticky STATUS.overrun.
REQ-021 SHALL let DATA writes during ACTIVE take effect immediately under the XOR.
REQ-022 SHALL let PULSE_LEN writes during ACTIVE affect only the next pulse.
REQ-023 SHALL define STATUS: bit0 busy (ACTIVE), bit1 done sticky, bit2 overrun sticky; addr3 write with bit1/bit2 set clears that flag.
REQ-024 SHALL give set priority over clear when done/overrun set and its clear write occur in the same cycle.
REQ-025 SHALL register irq high-level = done & IRQ_MASK[0], updating the cycle after done or mask changes.

Reset
REQ-026 SHALL, on reset_n low, asynchronously force: DATA=RESET_VALUE, out_port=RESET_VALUE, readdata=0, irq=0, PULSE_LEN=0, IRQ_MASK=0, done=0, overrun=0, mask=0, counter=0, state IDLE.
REQ-027 SHALL abort an in-progress pulse on reset with no done flag afterwards.

Configuration
REQ-028 SHALL, with macro NIOSV_SOC_GPO_PULSE_IRQ_EN defined, implement IRQ_MASK and irq per REQ-025.
REQ-029 SHALL, without NIOSV_SOC_GPO_PULSE_IRQ_EN, tie irq to 0, make addr4 read 0 and ignore writes; STATUS behaviour unchanged.

Verification
REQ-030 SHALL cover: reset, write DATA=0xA5 -> out_port 0xA5 next cycle, readback addr0 = 0x000000A5 one cycle after address.
REQ-031 SHALL cover: DATA=0x00, PULSE_LEN=5, write PULSE=0x81 -> out_port 0x81 exactly 5 cycles then 0x00; STATUS reads 0x2.
REQ-032 SHALL cover: PULSE_LEN=0, PULSE=0x01 -> 1-cycle pulse, done set.
REQ-033 SHALL cover: PULSE_LEN=10, PULSE=0x01, second PULSE=0x02 at cycle 3 -> only bit0 pulses, STATUS=0x5 during pulse, 0x6 after.
REQ-034 SHALL cover: IRQ_MASK=1, pulse completes -> irq=1; write STATUS=0x2 -> irq=0 next cycle; clear coinciding with done -> done stays 1.
REQ-035 SHALL cover: reset_n asserted mid-pulse (PULSE_LEN=100, cycle 20) -> out_port=RESET_VALUE immediately, STATUS=0 after release.
